move_cmd_gen: RTL and testbench

MOVE_CMD_GEN -- requirements
Module: move_cmd_gen

---
 rtl/move_cmd_gen.sv | 148 ++++++++++++++
 tb/tb_move_cmd_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_cmd_gen.sv
// Button front end: sync + debounce per bit, direction auto-repeat FSM, one-deep command register.
// Command appears 3+DEBOUNCE_CYCLES edges after a clean press; events arriving while a command is pending are dropped.
module move_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  input  logic       tick,
  output logic [3:0] cmd_dir,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       respawn,
  output logic       cmd_drop
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [4:0]     sync1_q, sync2_q;
  logic [4:0]     db_q, db_d;
  logic [DBW-1:0] db_cnt_q [5];
  logic [DBW-1:0] db_cnt_d [5];
  logic           db0_prev_q;
  state_t         state_q, state_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [3:0]     held_dir_q, held_dir_d;
  logic [3:0]     cmd_dir_q, cmd_dir_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic           respawn_q, respawn_d;
  logic           cmd_drop_q, cmd_drop_d;

  logic [3:0] dirs;
  logic       single_dir;
  logic       ev;
  logic       load;

  // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 5; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  assign dirs       = db_q[4:1];
  assign single_dir = $onehot(dirs);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    held_dir_d = held_dir_q;
    ev         = 1'b0;
    case (state_q)
      IDLE: begin
        if (single_dir) begin
          state_d    = DELAY;
          held_dir_d = dirs;
          tick_cnt_d = '0;
          ev         = 1'b1;
        end
      end
      DELAY: begin
        if (dirs != held_dir_q) begin
          state_d = IDLE;
        end else if (tick) begin
          if (tick_cnt_q == TW'(REPEAT_DELAY - 1)) begin
            state_d    = REPEAT;
            tick_cnt_d = '0;
            ev         = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      REPEAT: begin
        if (dirs != held_dir_q) begin
          state_d = IDLE;
        end else if (tick) begin
          if (tick_cnt_q == TW'(REPEAT_RATE - 1)) begin
            tick_cnt_d = '0;
            ev         = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An event loads only into an empty slot or one being accepted this cycle.
  always_comb begin
    load        = ev & (~cmd_valid_q | cmd_ready);
    cmd_valid_d = load | (cmd_valid_q & ~cmd_ready);
    cmd_dir_d   = load ? held_dir_d : cmd_dir_q;
    cmd_drop_d  = ev & ~load;
    respawn_d   = db_q[0] & ~db0_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
      db0_prev_q  <= 1'b0;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      held_dir_q  <= '0;
      cmd_dir_q   <= '0;
      cmd_valid_q <= 1'b0;
      respawn_q   <= 1'b0;
      cmd_drop_q  <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
      db0_prev_q  <= db_q[0];
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      held_dir_q  <= held_dir_d;
      cmd_dir_q   <= cmd_dir_d;
      cmd_valid_q <= cmd_valid_d;
      respawn_q   <= respawn_d;
      cmd_drop_q  <= cmd_drop_d;
    end
  end

  assign cmd_dir   = cmd_dir_q;
  assign cmd_valid = cmd_valid_q;
  assign respawn   = respawn_q;
  assign cmd_drop  = cmd_drop_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Randomized + directed bench for move_cmd_gen; a behavioural model predicts command, drop and respawn edges.
module tb_move_cmd_gen;
  localparam int DB = 4;
  localparam int RD = 3;
  localparam int RR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_raw = '0;
  logic       tick = 1'b0;
  logic       cmd_ready = 1'b1;
  logic [3:0] cmd_dir;
  logic       cmd_valid;
  logic       respawn;
  logic       cmd_drop;

  always #5 clk = ~clk;

  move_cmd_gen #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .tick(tick),
    .cmd_dir(cmd_dir), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .respawn(respawn), .cmd_drop(cmd_drop)
  );

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {int edge_n; logic [3:0] dir;} cmd_exp_t;
  cmd_exp_t cmd_q[$];
  int       drop_q[$];
  int       resp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
  endtask

  task automatic unexpected(input string name);
    checks++;
    $display("FAIL %s: output seen at edge %0d, none required", name, cyc);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // Reference model: evaluated on each rising edge with the pre-edge inputs.
  logic [4:0] m_s1, m_s2, m_db, s2_pre;
  logic [4:0] win [DB];
  logic       active, pend_v, ev, all_diff;
  logic [3:0] held, mdirs;
  int         n;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_s1 = '0; m_s2 = '0; m_db = '0;
        for (int k = 0; k < DB; k++) win[k] = '0;
        active = 1'b0; pend_v = 1'b0; held = '0; n = 0;
        cmd_q.delete(); drop_q.delete(); resp_q.delete();
      end else begin
        s2_pre = m_s2;
        mdirs  = m_db[4:1];
        ev     = 1'b0;
        if (active) begin
          if (mdirs != held) active = 1'b0;
          else if (tick) begin
            n++;
            if (n == RD || (n > RD && (n - RD) % RR == 0)) ev = 1'b1;
          end
        end else if ($countones(mdirs) == 1) begin
          active = 1'b1; held = mdirs; n = 0; ev = 1'b1;
        end
        if (ev) begin
          if (!pend_v || cmd_ready) begin
            pend_v = 1'b1;
            cmd_q.push_back('{cyc, held});
          end else begin
            drop_q.push_back(cyc);
          end
        end else if (pend_v && cmd_ready) begin
          pend_v = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = btn_raw;
        for (int k = DB - 1; k > 0; k--) win[k] = win[k-1];
        win[0] = s2_pre;
        for (int b = 0; b < 5; b++) begin
          all_diff = 1'b1;
          for (int k = 0; k < DB; k++) if (win[k][b] == m_db[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_db[b] = ~m_db[b];
            if (b == 0 && m_db[0]) resp_q.push_back(cyc + 1);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      tick = ((cyc % 4) == 3);
    end
  end

  // Monitor: pops the matching expectation whenever the DUT shows an output.
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [3:0] prev_dir = '0;
  cmd_exp_t   e;
  int         ie;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          check("held_valid", int'(cmd_valid), 1);
          check("held_dir", int'(cmd_dir), int'(prev_dir));
        end
        if (cmd_valid && !(prev_v && !prev_r)) begin
          if (cmd_q.size() == 0) unexpected("cmd");
          else begin
            e = cmd_q.pop_front();
            check("cmd_edge", cyc, e.edge_n);
            check("cmd_dir", int'(cmd_dir), int'(e.dir));
          end
        end
        if (cmd_drop) begin
          if (drop_q.size() == 0) unexpected("drop");
          else begin
            ie = drop_q.pop_front();
            check("drop_edge", cyc, ie);
          end
        end
        if (respawn) begin
          if (resp_q.size() == 0) unexpected("respawn");
          else begin
            ie = resp_q.pop_front();
            check("respawn_edge", cyc, ie);
          end
        end
        prev_v   = cmd_valid;
        prev_r   = cmd_ready;
        prev_dir = cmd_dir;
      end
    end
  end

  logic [4:0] pat [8];

  initial begin
    pat[0] = 5'b00000; pat[1] = 5'b00001; pat[2] = 5'b00010; pat[3] = 5'b00100;
    pat[4] = 5'b01000; pat[5] = 5'b10000; pat[6] = 5'b00110; pat[7] = 5'b00011;

    wait_cyc(3);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_dir", int'(cmd_dir), 0);
    check("rst_respawn", int'(respawn), 0);
    check("rst_drop", int'(cmd_drop), 0);
    rst = 1'b0;

    // clean press and release of up
    btn_raw = 5'b00010; wait_cyc(40);
    btn_raw = '0;       wait_cyc(20);
    // 3-cycle glitch on down
    btn_raw = 5'b10000; wait_cyc(3);
    btn_raw = '0;       wait_cyc(20);
    // backpressure while holding right
    cmd_ready = 1'b0;
    btn_raw = 5'b01000; wait_cyc(48);
    btn_raw = '0;       wait_cyc(10);
    cmd_ready = 1'b1;   wait_cyc(10);
    // up, then up+left, then left alone
    btn_raw = 5'b00010; wait_cyc(20);
    btn_raw = 5'b00110; wait_cyc(20);
    btn_raw = 5'b00100; wait_cyc(30);
    btn_raw = '0;       wait_cyc(15);
    // respawn alone and together with a direction
    btn_raw = 5'b00001; wait_cyc(20);
    btn_raw = '0;       wait_cyc(15);
    btn_raw = 5'b00011; wait_cyc(30);
    btn_raw = '0;       wait_cyc(15);

    for (int i = 0; i < 60; i++) begin
      btn_raw   = pat[$urandom_range(0, 7)];
      cmd_ready = ($urandom_range(0, 3) != 0);
      wait_cyc($urandom_range(1, 14));
    end
    btn_raw = '0; cmd_ready = 1'b1; wait_cyc(20);

    // reset while repeating with a pending command
    cmd_ready = 1'b0;
    btn_raw = 5'b10000; wait_cyc(30);
    check("pre_rst_valid", int'(cmd_valid), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(cmd_valid), 0);
    check("mid_rst_dir", int'(cmd_dir), 0);
    check("mid_rst_drop", int'(cmd_drop), 0);
    check("mid_rst_respawn", int'(respawn), 0);
    wait_cyc(2);
    rst = 1'b0; cmd_ready = 1'b1;
    wait_cyc(20);
    btn_raw = '0; wait_cyc(15);

    check("cmd_left", cmd_q.size(), 0);
    check("drop_left", drop_q.size(), 0);
    check("respawn_left", resp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1);
  end

endmodule
